// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the RV32I instruction fetch stage.
// Holds the NOP encoding, reset PC default and buffer entry layout.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count.
// Registered storage; data written this cycle is visible next cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd];
  assign o_count = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, credit-limited in-order imem reads.
// Buffers {pc, instr}; drops wrong-path responses after a redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC =
    ADDR_WIDTH'(RESET_PC_DFLT),
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [31:0]           imem_rdata_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  stall_i,
  output logic                  instr_valid_o,
  output logic [31:0]           instr_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_plus4_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned DW = CW + 4;
  localparam int unsigned EW = ADDR_WIDTH + 32;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT =
    {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DW-1:0]         r_drop;

  logic [CW-1:0]         w_pend_cnt;
  logic [CW-1:0]         w_buf_cnt;
  logic                  w_pend_empty;
  logic                  w_buf_empty;
  logic [ADDR_WIDTH-1:0] w_pend_pc;
  logic [EW-1:0]         w_head;
  logic [CW:0]           w_used;
  logic                  w_grant;
  logic                  w_resp;
  logic                  w_drop_hit;
  logic                  w_pop;
  logic [DW-1:0]         w_drop_sum;
  logic [DW-1:0]         w_drop_redir;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_unused;

  // Credit uses registered counts only; a pop this cycle frees nothing.
  assign w_used = {1'b0, w_pend_cnt} + {1'b0, w_buf_cnt};
  assign imem_req_o = !rst_i && !redirect_i &&
                      (w_used < (CW+1)'(DEPTH));
  assign imem_addr_o = r_pc;
  assign w_grant = imem_req_o && imem_gnt_i;

  assign w_drop_hit = imem_rvalid_i && (r_drop != '0);
  assign w_resp = imem_rvalid_i && !redirect_i &&
                  (r_drop == '0) && !w_pend_empty;
  assign w_pop = !w_buf_empty && !stall_i;

  // Everything still in flight at redirect is stale, minus this beat.
  assign w_drop_sum = r_drop + DW'(w_pend_cnt);
  assign w_drop_redir = (imem_rvalid_i && (w_drop_sum != '0)) ?
                        w_drop_sum - 1'b1 : w_drop_sum;
  assign w_target = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused = ^redirect_pc_i[1:0];

  sync_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_pend (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_flush (redirect_i),
    .i_push  (w_grant),
    .i_data  (r_pc),
    .i_pop   (w_resp),
    .o_data  (w_pend_pc),
    .o_count (w_pend_cnt),
    .o_empty (w_pend_empty)
  );

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_buf (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_flush (redirect_i),
    .i_push  (w_resp),
    .i_data  ({w_pend_pc, imem_rdata_i}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_buf_cnt),
    .o_empty (w_buf_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc   <= PC_INIT;
      r_drop <= '0;
    end else if (redirect_i) begin
      r_pc   <= w_target;
      r_drop <= w_drop_redir;
    end else begin
      if (w_grant)    r_pc   <= r_pc + PC_STEP;
      if (w_drop_hit) r_drop <= r_drop - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(imem_rvalid_i && (r_drop == '0) && w_pend_empty));
    end
  end

  assign instr_valid_o = !w_buf_empty;
  assign instr_o = instr_valid_o ? w_head[31:0] : NOP_INSTR;
  assign pc_o = instr_valid_o ? w_head[EW-1:32] : r_pc;
  assign pc_plus4_o = pc_o + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: latency-configurable memory model and an
// expected-instruction scoreboard checked as decode consumes outputs.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        mq[$];
  fetch_entry_t exp_q[$];
  int           mem_lat = 1;
  bit           mem_rnd = 1'b0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_errors = 0;

  fetch_unit #(
    .ADDR_WIDTH (32),
    .RESET_PC   (32'h0000_0000),
    .DEPTH      (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h0000_5A5A;
  endfunction

  task automatic push_stream(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + (32'(i) << 2);
      exp_q.push_back('{pc: a, instr: mem_data(a)});
    end
  endtask

  // Memory: in-order responses mem_lat cycles after each grant.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (mq.size() != 0 && mq[0].due <= cyc && !rst_i) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_data(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
      imem_gnt_i = mem_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #3;
      if (rst_i) mq.delete();
      else if (imem_req_o && imem_gnt_i)
        mq.push_back('{addr: imem_addr_o, due: cyc + mem_lat});
    end
  end

  task automatic do_reset(input int lat, input bit rnd);
    @(negedge clk);
    rst_i = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = '0;
    mem_lat = lat;
    mem_rnd = rnd;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    fetch_entry_t e;
    @(negedge clk);
    rst_i = 1'b1;
    mem_lat = 1;
    mem_rnd = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    #3;
    n_checks++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_ctrl: req %b valid %b, want 0 0",
               imem_req_o, instr_valid_o);
    end
    n_checks++;
    if (instr_o !== NOP_INSTR) begin
      n_errors++;
      $display("FAIL rst_instr: got %h, want %h", instr_o, NOP_INSTR);
    end
    n_checks++;
    if ({imem_addr_o, pc_o, pc_plus4_o} !== {32'h0, 32'h0, 32'h4}) begin
      n_errors++;
      $display("FAIL rst_pc: addr %h pc %h pc4 %h, want 0 0 4",
               imem_addr_o, pc_o, pc_plus4_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    push_stream(32'h0, 8);
    for (int c = 0; c < 40; c++) begin
      #3;
      if (c == 0) begin
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
          n_errors++;
          $display("FAIL first_req: req %b addr %h, want 1 0",
                   imem_req_o, imem_addr_o);
        end
      end
      if (c == 1 || c == 2) begin
        n_checks++;
        if (instr_valid_o !== (c == 2)) begin
          n_errors++;
          $display("FAIL latency c%0d: valid %b, want %b",
                   c, instr_valid_o, c == 2);
        end
      end
      if (instr_valid_o && !stall_i && !redirect_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL stream_extra: got pc %h, none expected", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({pc_o, instr_o, pc_plus4_o} !==
              {e.pc, e.instr, e.pc + 32'd4}) begin
            n_errors++;
            $display("FAIL stream: got %h %h %h, want %h %h %h",
                     pc_o, instr_o, pc_plus4_o,
                     e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL reset_timeout: %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    fetch_entry_t e;
    do_reset(1, 1'b0);
    push_stream(32'h0, 17);
    for (int c = 0; c < 80; c++) begin
      stall_i = (c >= 3 && c < 8);
      #3;
      if (c >= 3 && c < 8) begin
        n_checks++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h4) begin
          n_errors++;
          $display("FAIL stall_hold c%0d: valid %b pc %h, want 1 4",
                   c, instr_valid_o, pc_o);
        end
      end
      if (c >= 5 && c < 8) begin
        n_checks++;
        if (imem_req_o !== 1'b0) begin
          n_errors++;
          $display("FAIL stall_req c%0d: req %b, want 0", c, imem_req_o);
        end
      end
      if (instr_valid_o && !stall_i && !redirect_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL stream_extra: got pc %h, none expected", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({pc_o, instr_o, pc_plus4_o} !==
              {e.pc, e.instr, e.pc + 32'd4}) begin
            n_errors++;
            $display("FAIL stream: got %h %h %h, want %h %h %h",
                     pc_o, instr_o, pc_plus4_o,
                     e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (c >= 8 && exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL stall_timeout: %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_inflight();
    fetch_entry_t e;
    do_reset(3, 1'b0);
    redirect_pc_i = 32'h0000_0100;
    for (int c = 0; c < 80; c++) begin
      redirect_i = (c == 2);
      if (c == 2) push_stream(32'h100, 6);
      #3;
      if (c == 2) begin
        n_checks++;
        if (mq.size() != 2 || imem_req_o !== 1'b0) begin
          n_errors++;
          $display("FAIL redir_setup: inflight %0d req %b, want 2 0",
                   mq.size(), imem_req_o);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
          n_errors++;
          $display("FAIL redir_target: req %b addr %h, want 1 100",
                   imem_req_o, imem_addr_o);
        end
      end
      if (instr_valid_o && !stall_i && !redirect_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL stream_extra: got pc %h, none expected", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({pc_o, instr_o, pc_plus4_o} !==
              {e.pc, e.instr, e.pc + 32'd4}) begin
            n_errors++;
            $display("FAIL stream: got %h %h %h, want %h %h %h",
                     pc_o, instr_o, pc_plus4_o,
                     e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (c > 2 && exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL redir_timeout: %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_stall();
    fetch_entry_t e;
    do_reset(1, 1'b0);
    redirect_pc_i = 32'h0000_0203;
    for (int c = 0; c < 60; c++) begin
      redirect_i = (c == 2);
      stall_i = (c == 2);
      if (c == 2) push_stream(32'h200, 6);
      #3;
      if (c == 2) begin
        n_checks++;
        if (imem_rvalid_i !== 1'b1 || instr_valid_o !== 1'b1 ||
            pc_o !== 32'h0) begin
          n_errors++;
          $display("FAIL rs_setup: rvalid %b valid %b pc %h, want 1 1 0",
                   imem_rvalid_i, instr_valid_o, pc_o);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200 ||
            instr_valid_o !== 1'b0) begin
          n_errors++;
          $display("FAIL rs_target: req %b addr %h valid %b, want 1 200 0",
                   imem_req_o, imem_addr_o, instr_valid_o);
        end
      end
      if (instr_valid_o && !stall_i && !redirect_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL stream_extra: got pc %h, none expected", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({pc_o, instr_o, pc_plus4_o} !==
              {e.pc, e.instr, e.pc + 32'd4}) begin
            n_errors++;
            $display("FAIL stream: got %h %h %h, want %h %h %h",
                     pc_o, instr_o, pc_plus4_o,
                     e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (c > 2 && exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rs_timeout: %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    fetch_entry_t e;
    do_reset(1, 1'b1);
    redirect_pc_i = 32'hFFFF_FFF4;
    for (int c = 0; c < 120; c++) begin
      redirect_i = (c == 0);
      if (c == 0) push_stream(32'hFFFF_FFF4, 6);
      #3;
      if (c == 1) begin
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFF4) begin
          n_errors++;
          $display("FAIL wrap_target: req %b addr %h, want 1 fffffff4",
                   imem_req_o, imem_addr_o);
        end
      end
      if (instr_valid_o && !stall_i && !redirect_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL stream_extra: got pc %h, none expected", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({pc_o, instr_o, pc_plus4_o} !==
              {e.pc, e.instr, e.pc + 32'd4}) begin
            n_errors++;
            $display("FAIL stream: got %h %h %h, want %h %h %h",
                     pc_o, instr_o, pc_plus4_o,
                     e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (c > 0 && exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL wrap_timeout: %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    fetch_entry_t e;
    do_reset(2, 1'b1);
    push_stream(32'h0, 40);
    for (int c = 0; c < 500; c++) begin
      stall_i = ($urandom_range(0, 99) < 30);
      #3;
      if (instr_valid_o && !stall_i && !redirect_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL stream_extra: got pc %h, none expected", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({pc_o, instr_o, pc_plus4_o} !==
              {e.pc, e.instr, e.pc + 32'd4}) begin
            n_errors++;
            $display("FAIL stream: got %h %h %h, want %h %h %h",
                     pc_o, instr_o, pc_plus4_o,
                     e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    stall_i = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL random_timeout: %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    fetch_entry_t e;
    do_reset(2, 1'b0);
    for (int c = 0; c < 60; c++) begin
      stall_i = (c < 5);
      rst_i = (c == 3 || c == 4);
      if (c == 5) push_stream(32'h0, 6);
      #3;
      if (c == 3) begin
        n_checks++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h0) begin
          n_errors++;
          $display("FAIL mid_setup: valid %b pc %h, want 1 0",
                   instr_valid_o, pc_o);
        end
      end
      if (c == 4) begin
        n_checks++;
        if ({imem_req_o, instr_valid_o, instr_o, pc_o, imem_addr_o,
             pc_plus4_o} !==
            {1'b0, 1'b0, NOP_INSTR, 32'h0, 32'h0, 32'h4}) begin
          n_errors++;
          $display("FAIL mid_reset: req %b v %b i %h pc %h a %h p4 %h",
                   imem_req_o, instr_valid_o, instr_o, pc_o,
                   imem_addr_o, pc_plus4_o);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 ||
            instr_valid_o !== 1'b0) begin
          n_errors++;
          $display("FAIL mid_restart: req %b addr %h valid %b, want 1 0 0",
                   imem_req_o, imem_addr_o, instr_valid_o);
        end
      end
      if (instr_valid_o && !stall_i && !redirect_i && !rst_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL stream_extra: got pc %h, none expected", pc_o);
        end else begin
          e = exp_q.pop_front();
          if ({pc_o, instr_o, pc_plus4_o} !==
              {e.pc, e.instr, e.pc + 32'd4}) begin
            n_errors++;
            $display("FAIL stream: got %h %h %h, want %h %h %h",
                     pc_o, instr_o, pc_plus4_o,
                     e.pc, e.instr, e.pc + 32'd4);
          end
        end
      end
      if (c > 5 && exp_q.size() == 0) break;
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL mid_timeout: %0d left, want 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect_inflight();
    test_redirect_stall();
    test_wrap();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
